hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: RsD, RtD  in  5 each  ID-stage source registers.
REQ-004 SHALL have: RsE, RtE  in  5 each  EX-stage source registers.
REQ-005 SHALL have: WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage.
REQ-006 SHALL have: RegWriteE, RegWriteM, RegWriteW  in  1 each  stage writes the register file.
REQ-007 SHALL have: MemtoRegE, MemtoRegM  in  1 each  stage holds a load.
REQ-008 SHALL have: BranchD, Jump_RD  in  1 each  ID holds a branch or a jump-register.
REQ-009 SHALL have: MdStartE  in  1  EX issues a multiply/divide; MdDivE  in  1  1 = divide, 0 = multiply.
REQ-010 SHALL have: MdUseD  in  1  ID reads HI/LO or issues a multiply/divide.
REQ-011 SHALL have: StallF, StallD  out  1 each  hold the PC and IF/ID registers.
REQ-012 SHALL have: FlushE  out  1  drives the ID/EX pipeline-register clr input (bubble insert).
REQ-013 SHALL have: ForwardAD, ForwardBD  out  1 each  1 = ID comparator operand taken from the MEM ALU result.
REQ-014 SHALL have: ForwardAE, ForwardBE  out  2 each  00 = register file, 01 = WB result, 10 = MEM ALU result.
REQ-015 SHALL have: MdBusy  out  1; StallCount  out  32  count of stalled cycles.

Function
REQ-016 A register match SHALL require a non-zero register number and an asserted RegWrite for the producing stage; $0 SHALL never match.
REQ-017 ForwardAE SHALL be 10 on a MEM match with RsE, otherwise 01 on a WB match, otherwise 00; MEM SHALL take priority. ForwardBE SHALL follow the same rule using RtE.
REQ-018 ForwardAD/ForwardBD SHALL be 1 only on a MEM match with RsD/RtD.
REQ-019 lwstall SHALL be MemtoRegE and WriteRegE non-zero and WriteRegE equal to RsD or RtD.
REQ-020 brstall SHALL be (BranchD or Jump_RD) and either (a) an EX match with RsD/RtD, or (b) MemtoRegM and a MEM match with RsD/RtD.
REQ-021 The MD counter (4 bit) SHALL load 5 on MdStartE with MdDivE=0, and load 10 on MdStartE with MdDivE=1; otherwise it SHALL decrement when non-zero and hold at 0.
REQ-022 MdBusy SHALL be high exactly when the counter is non-zero.
REQ-023 mdstall SHALL be MdUseD and (MdBusy or MdStartE).
REQ-024 Stall = lwstall or brstall or mdstall; StallF = StallD = FlushE = Stall, all combinational and in the same cycle.
REQ-025 MdStartE while MdBusy SHALL be ignored; the counter SHALL continue decrementing.
REQ-026 StallCount SHALL increment by 1 each cycle Stall is high and SHALL saturate at 0xFFFFFFFF.
REQ-027 Forwarding outputs SHALL remain valid during a stall.

Reset
REQ-028 On reset, the MD counter and StallCount SHALL be cleared to 0, so MdBusy = 0.
REQ-029 In the reset cycle, all outputs SHALL evaluate from the inputs with the counter treated as 0.
REQ-030 Reset during a multiply/divide SHALL abort it; MdStartE in the reset cycle SHALL be ignored.

Structure
REQ-031 The MD latencies (5, 10) and the forward-select encodings SHALL be constants in the shared macro header.
REQ-032 Forwarding logic SHALL be a single sub-module, fwd_unit, instantiated once for the EX operands and once for the ID operands.

Verification
REQ-033 WriteRegM=8, RegWriteM=1, WriteRegW=8, RegWriteW=1, RsE=8 -> ForwardAE=10; with RegWriteM=0 -> 01; with all WriteReg=0 -> 00.
REQ-034 MemtoRegE=1, WriteRegE=9, RtD=9 -> StallF=StallD=FlushE=1 for one cycle; StallCount 0->1.
REQ-035 BranchD=1, RegWriteE=1, WriteRegE=4, RsD=4 -> stall; next cycle, with the producer in MEM (non-load) -> no stall and ForwardAD=1.
REQ-036 MdStartE=1, MdDivE=1, then MdUseD=1 -> MdBusy high for 10 cycles; stall held 11 cycles (start cycle included); release on the cycle the counter reads 0.
REQ-037 Reset asserted at counter=3 -> MdBusy=0 on the next cycle, StallCount=0, with MdUseD=1 producing no stall.
REQ-038 Force StallCount to 0xFFFFFFFE and hold a stall for 3 cycles -> StallCount reads 0xFFFFFFFF and holds.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller:
// multiply/divide latencies and forward-select encodings.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] MD_MUL_LAT = 4'd5;
    localparam logic [CNT_W-1:0] MD_DIV_LAT = 4'd10;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // $0 is hard-wired, so it never counts as a produced value.
    function automatic logic reg_match(input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] dst,
                                       input logic             we);
        return we && (dst != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forward-select for one operand pair; MEM wins over WB.
// Instantiated for the EX operands and again for the ID comparator operands.
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic [REG_W-1:0] wr_m_i,
    input  logic             we_m_i,
    input  logic [REG_W-1:0] wr_w_i,
    input  logic             we_w_i,
    output fwd_sel_e         fwd_a_o,
    output fwd_sel_e         fwd_b_o
);

    always_comb begin
        fwd_a_o = FWD_RF;
        if (reg_match(rs_i, wr_m_i, we_m_i))      fwd_a_o = FWD_MEM;
        else if (reg_match(rs_i, wr_w_i, we_w_i)) fwd_a_o = FWD_WB;
    end

    always_comb begin
        fwd_b_o = FWD_RF;
        if (reg_match(rt_i, wr_m_i, we_m_i))      fwd_b_o = FWD_MEM;
        else if (reg_match(rt_i, wr_w_i, we_w_i)) fwd_b_o = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load/branch/mul-div stalls,
// mul-div busy counter and a saturating stalled-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             Jump_RD,
    input  logic             MdStartE,
    input  logic             MdDivE,
    input  logic             MdUseD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MdBusy,
    output logic [31:0]      StallCount
);

    fwd_sel_e fwd_ae, fwd_be, fwd_ad, fwd_bd;

    fwd_unit u_fwd_ex (
        .rs_i   (RsE),       .rt_i   (RtE),
        .wr_m_i (WriteRegM), .we_m_i (RegWriteM),
        .wr_w_i (WriteRegW), .we_w_i (RegWriteW),
        .fwd_a_o(fwd_ae),    .fwd_b_o(fwd_be)
    );

    fwd_unit u_fwd_id (
        .rs_i   (RsD),       .rt_i   (RtD),
        .wr_m_i (WriteRegM), .we_m_i (RegWriteM),
        .wr_w_i (WriteRegW), .we_w_i (RegWriteW),
        .fwd_a_o(fwd_ad),    .fwd_b_o(fwd_bd)
    );

    assign ForwardAE = fwd_ae;
    assign ForwardBE = fwd_be;
    // The ID comparator only has a path from the MEM ALU result.
    assign ForwardAD = (fwd_ad == FWD_MEM);
    assign ForwardBD = (fwd_bd == FWD_MEM);

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic             lwstall, brstall, mdstall, stall;

    // Counter reads as idle during reset so the reset cycle is stall-free.
    assign MdBusy = !reset && (md_cnt_q != '0);

    always_comb begin
        lwstall = MemtoRegE && (WriteRegE != '0) &&
                  ((WriteRegE == RsD) || (WriteRegE == RtD));
        brstall = (BranchD || Jump_RD) &&
                  (reg_match(RsD, WriteRegE, RegWriteE) ||
                   reg_match(RtD, WriteRegE, RegWriteE) ||
                   (MemtoRegM && (reg_match(RsD, WriteRegM, RegWriteM) ||
                                  reg_match(RtD, WriteRegM, RegWriteM))));
        mdstall = MdUseD && (MdBusy || MdStartE);
        stall   = lwstall || brstall || mdstall;
    end

    assign StallF     = stall;
    assign StallD     = stall;
    assign FlushE     = stall;
    assign StallCount = stall_cnt_q;

    // A new start while busy is dropped; the running operation keeps counting.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (MdStartE && !MdBusy) md_cnt_d = MdDivE ? MD_DIV_LAT : MD_MUL_LAT;
        else if (md_cnt_q != '0) md_cnt_d = md_cnt_q - 1'b1;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: rule-level model checked every cycle, plus
// hand-computed scenario expectations.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, Jump_RD, MdStartE, MdDivE, MdUseD;
    logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, MdBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic [31:0] StallCount;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .Jump_RD(Jump_RD),
        .MdStartE(MdStartE), .MdDivE(MdDivE), .MdUseD(MdUseD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy), .StallCount(StallCount)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_cnt = 0;          // remaining mul/div cycles
    longint m_sc  = 0;          // stalled cycles, saturating
    bit     started = 0;

    function automatic bit produced(input logic [4:0] src, input logic [4:0] dst, input logic we);
        return (src != 0) && we && (src == dst);
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (produced(src, WriteRegM, RegWriteM)) return 2'd2;
        if (produced(src, WriteRegW, RegWriteW)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit exp_busy();
        return !reset && (m_cnt > 0);
    endfunction

    function automatic bit exp_stall();
        bit lw, br, md;
        lw = MemtoRegE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
        br = (BranchD || Jump_RD) &&
             (produced(RsD, WriteRegE, RegWriteE) || produced(RtD, WriteRegE, RegWriteE) ||
              (MemtoRegM && (produced(RsD, WriteRegM, RegWriteM) || produced(RtD, WriteRegM, RegWriteM))));
        md = MdUseD && (exp_busy() || MdStartE);
        return lw || br || md;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0;
            m_sc  = 0;
        end else begin
            if (exp_stall() && m_sc < 64'hFFFF_FFFF) m_sc = m_sc + 1;
            if (MdStartE && m_cnt == 0) m_cnt = MdDivE ? 10 : 5;
            else if (m_cnt > 0)         m_cnt = m_cnt - 1;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("StallF",     {31'd0, StallF},    {31'd0, exp_stall()});
            check("StallD",     {31'd0, StallD},    {31'd0, exp_stall()});
            check("FlushE",     {31'd0, FlushE},    {31'd0, exp_stall()});
            check("ForwardAE",  {30'd0, ForwardAE}, {30'd0, exp_fwd(RsE)});
            check("ForwardBE",  {30'd0, ForwardBE}, {30'd0, exp_fwd(RtE)});
            check("ForwardAD",  {31'd0, ForwardAD}, {31'd0, produced(RsD, WriteRegM, RegWriteM)});
            check("ForwardBD",  {31'd0, ForwardBD}, {31'd0, produced(RtD, WriteRegM, RegWriteM)});
            check("MdBusy",     {31'd0, MdBusy},    {31'd0, exp_busy()});
            check("StallCount", StallCount,         m_sc[31:0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_inputs();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
        {BranchD, Jump_RD, MdStartE, MdDivE, MdUseD} = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [4:0] rse, rte, rsd, rtd, wre, wrm, wrw;
        logic [7:0] flags; // RegWriteE,M,W, MemtoRegE,M, BranchD, Jump_RD, MdUseD
    } vec_t;

    vec_t vecs [6];
    int   n_stall, n_busy;

    initial begin
        vecs[0] = '{3, 7, 0, 0, 0, 3, 7, 8'b0110_0000};
        vecs[1] = '{5, 5, 0, 0, 0, 5, 5, 8'b0010_0000};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 8'b1110_0000};
        vecs[3] = '{1, 2, 6, 7, 7, 6, 2, 8'b1110_0010};
        vecs[4] = '{4, 4, 11, 12, 0, 12, 4, 8'b0111_1100};
        vecs[5] = '{9, 9, 13, 14, 14, 0, 9, 8'b0010_1000};

        clear_inputs();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset_StallCount", StallCount, 32'd0);
        check("reset_MdBusy", {31'd0, MdBusy}, 32'd0);
        tick();

        // MEM beats WB; then WB alone; then nothing valid.
        WriteRegM = 8; RegWriteM = 1; WriteRegW = 8; RegWriteW = 1; RsE = 8;
        @(negedge clk); check("fwdAE_mem", {30'd0, ForwardAE}, 32'd2);
        tick(); RegWriteM = 0;
        @(negedge clk); check("fwdAE_wb", {30'd0, ForwardAE}, 32'd1);
        tick(); RegWriteM = 1; WriteRegM = 0; WriteRegW = 0;
        @(negedge clk); check("fwdAE_zero", {30'd0, ForwardAE}, 32'd0);
        tick(); clear_inputs();

        foreach (vecs[i]) begin
            {RsE, RtE, RsD, RtD} = {vecs[i].rse, vecs[i].rte, vecs[i].rsd, vecs[i].rtd};
            {WriteRegE, WriteRegM, WriteRegW} = {vecs[i].wre, vecs[i].wrm, vecs[i].wrw};
            {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, Jump_RD, MdUseD} = vecs[i].flags;
            tick();
        end
        clear_inputs();
        reset = 1'b1; tick(); reset = 1'b0;

        // Load-use stall lasts one cycle and bumps the counter once.
        MemtoRegE = 1; WriteRegE = 9; RtD = 9;
        @(negedge clk);
        check("lw_stall", {29'd0, StallF, StallD, FlushE}, 32'd7);
        check("lw_cnt0", StallCount, 32'd0);
        tick(); clear_inputs();
        @(negedge clk);
        check("lw_release", {31'd0, StallF}, 32'd0);
        check("lw_cnt1", StallCount, 32'd1);
        tick();

        // Branch on an EX producer stalls; once it is in MEM it forwards.
        BranchD = 1; RegWriteE = 1; WriteRegE = 4; RsD = 4;
        @(negedge clk); check("br_stall", {31'd0, StallD}, 32'd1);
        tick();
        RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 4;
        @(negedge clk);
        check("br_nostall", {31'd0, StallD}, 32'd0);
        check("br_fwdAD", {31'd0, ForwardAD}, 32'd1);
        tick(); clear_inputs();

        // Divide: 10 busy cycles, 11 stalled cycles, release when idle.
        MdStartE = 1; MdDivE = 1; MdUseD = 1;
        n_stall = 0; n_busy = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_stall += int'(StallF);
            n_busy  += int'(MdBusy);
            if (c == 11) check("div_release", {31'd0, StallF}, 32'd0);
            tick();
            MdStartE = 0; MdDivE = 0;
        end
        check("div_stall_cycles", n_stall, 32'd11);
        check("div_busy_cycles", n_busy, 32'd10);
        clear_inputs();

        // Reset mid-divide aborts it.
        MdStartE = 1; MdDivE = 1; tick(); MdStartE = 0; MdDivE = 0;
        repeat (7) tick();   // counter now 3
        @(negedge clk); check("abort_busy_before", {31'd0, MdBusy}, 32'd1);
        tick();
        reset = 1; MdUseD = 1;
        @(negedge clk); check("abort_reset_cycle_stall", {31'd0, StallF}, 32'd0);
        tick(); reset = 0;
        @(negedge clk);
        check("abort_busy", {31'd0, MdBusy}, 32'd0);
        check("abort_cnt", StallCount, 32'd0);
        check("abort_nostall", {31'd0, StallF}, 32'd0);
        tick(); clear_inputs();

        // Saturation near the top of the stall counter.
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        m_sc = 64'hFFFF_FFFE;
        #1 release dut.stall_cnt_q;
        MemtoRegE = 1; WriteRegE = 3; RsD = 3;
        repeat (3) tick();
        @(negedge clk); check("sat_max", StallCount, 32'hFFFF_FFFF);
        tick();
        @(negedge clk); check("sat_hold", StallCount, 32'hFFFF_FFFF);
        tick(); clear_inputs();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
